msk_tx_phase_gen: RTL

- Transmit-side MSK symbol timing and phase generator; the counterpart of the receiver timing-recovery phase accumulator.
- Accepts one data bit per symbol over a valid/ready handshake and advances a continuous-phase accumulator by ±1/4 cycle per symbol, spread across OSF samples.
- Produces one phase word per sample-enable cycle for the downstream sin/cos LUT and DAC path.

---
 rtl/msk_tx_phase_gen.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/msk_tx_phase_gen.sv
// rtl/msk_tx_phase_gen.sv - MSK transmit symbol timing and continuous-phase generator
//
// Takes one data bit per symbol through a 1-deep holding register and spreads a
// +/- quarter-cycle phase advance over OSF sample-enable cycles. Index 0 of each
// symbol carries the division remainder so that a full symbol advances by exactly
// 2^(PHASE_W-2) and the phase never drifts.
//
// Optional build macro: MSK_TX_DIFF_ENC_EN - differentially encode the data bit at
// load (d_k = bit_k ^ d_{k-1}); the previous transmitted bit is only cleared by reset.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   en_i          sample enable; one phase sample per enabled cycle
//   bit_i         data bit (1 = phase increasing, 0 = phase decreasing)
//   bit_val_i     bit_i valid
//   bit_rdy_o     holding register empty, bit can be accepted
//   phase_o       current phase word, unsigned modulo 2^PHASE_W
//   sample_val_o  phase_o updated this cycle
//   sym_strobe_o  pulse on the first sample of each symbol
//   sym_idx_o     sample index within the symbol, 0..OSF-1
//   underrun_o    pulse when a symbol boundary is reached with no bit held

module msk_tx_phase_gen #(
  parameter int OSF       = 20,
  parameter int PHASE_W   = 32,
  parameter int SYM_CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic                 bit_i,
  input  logic                 bit_val_i,
  output logic                 bit_rdy_o,
  output logic [PHASE_W-1:0]   phase_o,
  output logic                 sample_val_o,
  output logic                 sym_strobe_o,
  output logic [SYM_CNT_W-1:0] sym_idx_o,
  output logic                 underrun_o
);

  localparam logic [PHASE_W-1:0]   QUARTER  = PHASE_W'(1) << (PHASE_W - 2);
  localparam logic [PHASE_W-1:0]   OSF_W    = PHASE_W'(OSF);
  localparam logic [PHASE_W-1:0]   STEP     = QUARTER / OSF_W;
  // First sample of a symbol also absorbs the remainder of the division.
  localparam logic [PHASE_W-1:0]   STEP0    = STEP + (QUARTER - OSF_W * STEP);
  localparam logic [SYM_CNT_W-1:0] LAST_IDX = SYM_CNT_W'(OSF - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [SYM_CNT_W-1:0] sym_idx_q, sym_idx_d;
  logic                 sample_val_q, sample_val_d;
  logic                 sym_strobe_q, sym_strobe_d;
  logic                 underrun_q, underrun_d;
  logic                 hold_full_q, hold_full_d;
  logic                 hold_bit_q, hold_bit_d;
  logic                 cur_bit_q, cur_bit_d;

  logic                 load_bit;
  logic                 do_load;
  logic                 do_step;
  logic                 step_dir;
  logic [PHASE_W-1:0]   step_inc;

`ifdef MSK_TX_DIFF_ENC_EN
  // cur_bit_q holds d_{k-1}; it survives IDLE/underrun and is cleared only by reset.
  assign load_bit = hold_bit_q ^ cur_bit_q;
`else
  assign load_bit = hold_bit_q;
`endif

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    sym_idx_d    = sym_idx_q;
    sample_val_d = 1'b0;
    sym_strobe_d = 1'b0;
    underrun_d   = 1'b0;
    hold_full_d  = hold_full_q;
    hold_bit_d   = hold_bit_q;
    cur_bit_d    = cur_bit_q;
    do_load      = 1'b0;
    do_step      = 1'b0;
    step_dir     = cur_bit_q;
    step_inc     = STEP;

    // Acceptance needs an empty holder while loading needs a full one, so a bit
    // can never be accepted and consumed in the same cycle.
    if (bit_val_i && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_bit_d  = bit_i;
    end

    unique case (state_q)
      IDLE: begin
        if (en_i && hold_full_q) begin
          do_load = 1'b1;
        end
      end
      RUN: begin
        if (en_i) begin
          if (sym_idx_q != LAST_IDX) begin
            sym_idx_d    = sym_idx_q + 1'b1;
            do_step      = 1'b1;
            sample_val_d = 1'b1;
          end else if (hold_full_q) begin
            do_load = 1'b1;
          end else begin
            underrun_d = 1'b1;
            sym_idx_d  = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      cur_bit_d    = load_bit;
      hold_full_d  = 1'b0;
      sym_idx_d    = '0;
      do_step      = 1'b1;
      step_dir     = load_bit;
      step_inc     = STEP0;
      sample_val_d = 1'b1;
      sym_strobe_d = 1'b1;
      state_d      = RUN;
    end

    if (do_step) begin
      phase_d = step_dir ? (phase_q + step_inc) : (phase_q - step_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      sym_idx_q    <= '0;
      sample_val_q <= 1'b0;
      sym_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_bit_q   <= 1'b0;
      cur_bit_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sym_idx_q    <= sym_idx_d;
      sample_val_q <= sample_val_d;
      sym_strobe_q <= sym_strobe_d;
      underrun_q   <= underrun_d;
      hold_full_q  <= hold_full_d;
      hold_bit_q   <= hold_bit_d;
      cur_bit_q    <= cur_bit_d;
    end
  end

  assign bit_rdy_o    = !hold_full_q;
  assign phase_o      = phase_q;
  assign sample_val_o = sample_val_q;
  assign sym_strobe_o = sym_strobe_q;
  assign sym_idx_o    = sym_idx_q;
  assign underrun_o   = underrun_q;

endmodule
